// File: rtl/adc733_sport_emu.sv
// adc733_sport_emu: device-side emulator of the 733-series serial port.
// Generates SCLK/SDOFS/SDO frames, receives SDIFS/SDI control words into an
// 8x8 register file and switches from program mode to data mode.
// Optional build macro ADC733_EMU_ECHO_EN: program-mode frames echo the last
// received word instead of 0x0000.
module adc733_sport_emu #(
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned NUM_CH    = 6,
    parameter int unsigned FRAME_GAP = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        se,
    input  logic        sdifs,
    input  logic        sdi,
    output logic        sclk,
    output logic        sdofs,
    output logic        sdo,
    output logic        data_mode,
    output logic [2:0]  channel,
    output logic        rx_valid,
    output logic [15:0] rx_word,
    output logic        reg_wr,
    output logic [2:0]  reg_addr,
    output logic [7:0]  reg_data
);

    localparam int unsigned DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned SMP_W  = 13;
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_BITS, TX_GAP} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_SHIFT}                  rx_state_t;

    // ------------------------------------------------------------------
    // SCLK divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic             tick_c;
    logic             rise_c;
    logic             fall_c;

    assign tick_c = se && (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign rise_c = tick_c && !phase;
    assign fall_c = tick_c && phase;

    // Divider counter and serial clock; se=0 freezes the phase and parks sclk low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
            sclk    <= 1'b0;
        end else if (!se) begin
            sclk    <= 1'b0;
        end else if (tick_c) begin
            div_cnt <= '0;
            phase   <= !phase;
            sclk    <= !phase;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            sclk    <= phase;
        end
    end

    // ------------------------------------------------------------------
    // TX frame FSM (advances on SCLK fall)
    // ------------------------------------------------------------------
    tx_state_t          tx_state;
    tx_state_t          tx_state_nxt;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_idx_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_nxt;
    logic               sdo_nxt;
    logic               sdofs_nxt;
    logic               sync_entry_c;
    logic [WORD_W-1:0]  tx_word;
    logic [WORD_W-1:0]  prog_word_c;
    logic [SMP_W-1:0]   sample_cnt;
    logic [2:0]         ch_step_c;
    logic [SMP_W-1:0]   smp_step_c;
    logic               mode_pending;

`ifdef ADC733_EMU_ECHO_EN
    assign prog_word_c = rx_word;
`else
    assign prog_word_c = '0;
`endif

    // TX state register and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            sdo      <= 1'b0;
            sdofs    <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            bit_idx  <= bit_idx_nxt;
            gap_cnt  <= gap_cnt_nxt;
            sdo      <= sdo_nxt;
            sdofs    <= sdofs_nxt;
        end
    end

    // TX next-state and next serial output values.
    always_comb begin
        tx_state_nxt = tx_state;
        bit_idx_nxt  = bit_idx;
        gap_cnt_nxt  = gap_cnt;
        sdo_nxt      = sdo;
        sdofs_nxt    = sdofs;
        sync_entry_c = 1'b0;
        if (fall_c) begin
            case (tx_state)
                TX_IDLE: sync_entry_c = 1'b1;
                TX_SYNC: begin
                    tx_state_nxt = TX_BITS;
                    bit_idx_nxt  = BIT_W'(WORD_W - 1);
                    sdofs_nxt    = 1'b0;
                    sdo_nxt      = tx_word[WORD_W-1];
                end
                TX_BITS: begin
                    if (bit_idx == '0) begin
                        if (FRAME_GAP == 0) begin
                            sync_entry_c = 1'b1;
                        end else begin
                            tx_state_nxt = TX_GAP;
                            gap_cnt_nxt  = '0;
                            sdo_nxt      = 1'b0;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx - BIT_W'(1);
                        sdo_nxt     = tx_word[bit_idx_nxt];
                    end
                end
                TX_GAP: begin
                    if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
                        sync_entry_c = 1'b1;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                default: tx_state_nxt = TX_IDLE;
            endcase
            if (sync_entry_c) begin
                tx_state_nxt = TX_SYNC;
                sdofs_nxt    = 1'b1;
                sdo_nxt      = 1'b0;
            end
        end
    end

    // Channel/sample advance for the next data frame.
    always_comb begin
        ch_step_c  = channel + 3'd1;
        smp_step_c = sample_cnt;
        if (channel == 3'(NUM_CH - 1)) begin
            ch_step_c  = 3'd0;
            smp_step_c = sample_cnt + SMP_W'(1);
        end
    end

    // Frame word latch and mode switch, both taken at SYNC entry only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_word    <= '0;
            data_mode  <= 1'b0;
            channel    <= '0;
            sample_cnt <= '0;
        end else if (sync_entry_c) begin
            if (data_mode) begin
                channel    <= ch_step_c;
                sample_cnt <= smp_step_c;
                tx_word    <= {ch_step_c, smp_step_c};
            end else if (mode_pending) begin
                data_mode  <= 1'b1;
                channel    <= '0;
                sample_cnt <= '0;
                tx_word    <= '0;
            end else begin
                tx_word    <= prog_word_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX control-word FSM (advances on SCLK rise)
    // ------------------------------------------------------------------
    rx_state_t          rx_state;
    rx_state_t          rx_state_nxt;
    logic [BIT_W-1:0]   rx_cnt;
    logic [BIT_W-1:0]   rx_cnt_nxt;
    logic [WORD_W-1:0]  shift;
    logic [WORD_W-1:0]  shift_nxt;
    logic               rx_done_c;
    logic               rx_wr_c;
    logic [2:0]         wr_addr_c;
    logic [7:0]         wr_data_c;
    logic [7:0]         regfile [8];

    assign rx_wr_c   = rx_done_c && shift_nxt[15];
    assign wr_addr_c = shift_nxt[10:8];
    assign wr_data_c = shift_nxt[7:0];

    // Last written data, read back from the register file.
    assign reg_data  = regfile[reg_addr];

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            shift    <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            shift    <= shift_nxt;
        end
    end

    // RX next-state: arm on sdifs while idle, then shift 16 bits MSB first.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        shift_nxt    = shift;
        rx_done_c    = 1'b0;
        if (rise_c) begin
            case (rx_state)
                RX_IDLE: begin
                    if (sdifs) begin
                        rx_state_nxt = RX_SHIFT;
                        rx_cnt_nxt   = '0;
                    end
                end
                RX_SHIFT: begin
                    shift_nxt = {shift[WORD_W-2:0], sdi};
                    if (rx_cnt == BIT_W'(WORD_W - 1)) begin
                        rx_state_nxt = RX_IDLE;
                        rx_done_c    = 1'b1;
                    end else begin
                        rx_cnt_nxt = rx_cnt + BIT_W'(1);
                    end
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // Received-word decode: register writes and the mode-switch request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid     <= 1'b0;
            reg_wr       <= 1'b0;
            rx_word      <= '0;
            reg_addr     <= '0;
            mode_pending <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            rx_valid <= rx_done_c;
            reg_wr   <= rx_wr_c;
            if (rx_done_c) begin
                rx_word <= shift_nxt;
            end
            if (rx_wr_c) begin
                regfile[wr_addr_c] <= wr_data_c;
                reg_addr           <= wr_addr_c;
                if (wr_addr_c == 3'd0 && wr_data_c[0]) begin
                    mode_pending <= 1'b1;
                end
            end
        end
    end

endmodule
